// File: rtl/memory_arbiter.sv
// memory_arbiter: merges dcache-FSM and icache word requests onto one RAM port, dcache priority with icache anti-starvation
//  Ports: CLK, RST (async, active-high)
//   icache : iREN, iaddr -> iwait, iload
//   dcache : dREN, dWEN, daddr, dstore -> dwait, dload
//   RAM    : ramREN, ramWEN, ramaddr, ramstore -> ramload, ramstate (00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR)
//   MEMARB_STATS_EN adds dgrants, igrants, errcycles (32-bit wrapping counters)
module memory_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int CNT_W = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef MEMARB_STATS_EN
  ,
  output logic [31:0] dgrants,
  output logic [31:0] igrants,
  output logic [31:0] errcycles
`endif
);
  typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;
  state_t state;
  logic [CNT_W-1:0] streak;
  logic dReq, access, starve;
  assign dReq = dREN | dWEN;
  assign access = ramstate == 2'b10;
  // icache is forced through only when it is actually waiting and the dcache has used its streak
  assign starve = iREN && streak == CNT_W'(MAX_DSTREAK);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      streak <= '0;
    end else
      case (state)
        IDLE: state <= (dReq && !starve) ? DGNT : iREN ? IGNT : IDLE;
        DGNT:
          if (!dReq) begin
            state <= IDLE;
            streak <= !iREN ? '0 : (streak == CNT_W'(MAX_DSTREAK)) ? streak : streak + CNT_W'(1);
          end
        IGNT: begin
          streak <= '0;
          if (access || !iREN) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  // RAM side follows the owner's request lines directly so a dropped request releases the RAM the same cycle
  assign ramREN = (state == DGNT) ? (dREN && !dWEN) : (state == IGNT && iREN);
  assign ramWEN = state == DGNT && dWEN;
  assign ramaddr = (state == DGNT) ? daddr : (state == IGNT) ? iaddr : '0;
  assign ramstore = (state == DGNT) ? dstore : '0;
  assign dwait = !(state == DGNT && access);
  assign iwait = !(state == IGNT && access);
  assign iload = ramload;
  assign dload = ramload;
  assert property (@(posedge CLK) disable iff (RST) !(dREN && dWEN));
`ifdef MEMARB_STATS_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      dgrants <= '0;
      igrants <= '0;
      errcycles <= '0;
    end else begin
      if (state == DGNT && access) dgrants <= dgrants + 32'd1;
      if (state == IGNT && access) igrants <= igrants + 32'd1;
      if (state != IDLE && ramstate == 2'b11) errcycles <= errcycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: table-driven cycle vectors plus hand sequences for reset and error-retry writeback
module tb_memory_arbiter;
  localparam logic [1:0] FR = 2'b00, BS = 2'b01, AC = 2'b10, ER = 2'b11;
  logic CLK = 0, RST = 1;
  logic iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  logic [1:0] ramstate = FR;
  logic iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEMARB_STATS_EN
  logic [31:0] dgrants, igrants, errcycles;
`endif
  int tests = 0, fails = 0;
  memory_arbiter dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEMARB_STATS_EN
    , .dgrants(dgrants), .igrants(igrants), .errcycles(errcycles)
`endif
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic ir, dr, dw;
    logic [1:0] rs;
    logic [31:0] ia, da, ds;
    logic ren, wen;
    logic [31:0] addr, st;
    logic iw, dwt;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(logic ir, dr, dw, logic [1:0] rs, logic [31:0] ia, da, ds,
                              logic ren, wen, logic [31:0] addr, st, logic iw, dwt);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.rs = rs; v.ia = ia; v.da = da; v.ds = ds;
    v.ren = ren; v.wen = wen; v.addr = addr; v.st = st; v.iw = iw; v.dwt = dwt;
    return v;
  endfunction
  task automatic chk(string name, logic [67:0] got, logic [67:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got ren,wen,iw,dw,addr,store=%h required %h", name, got, exp);
    end
  endtask
  function automatic logic [67:0] outs();
    return {ramREN, ramWEN, iwait, dwait, ramaddr, ramstore};
  endfunction
  task automatic apply(vec_t v, int idx);
    @(negedge CLK);
    iREN = v.ir; dREN = v.dr; dWEN = v.dw; ramstate = v.rs;
    iaddr = v.ia; daddr = v.da; dstore = v.ds;
    ramload = 32'hC0DE_0000 + 32'(idx);
    #1;
    chk($sformatf("vec%0d", idx), outs(), {v.ren, v.wen, v.iw, v.dwt, v.addr, v.st});
    tests++;
    if (iload !== ramload || dload !== ramload) begin
      fails++;
      $display("FAIL load%0d: got iload=%h dload=%h required %h", idx, iload, dload, ramload);
    end
  endtask
  initial begin
    // icache word at 0x40, two BUSY then ACCESS
    vecs.push_back(mk(1,0,0,FR,32'h40,0,0, 0,0,0,0,1,1));
    vecs.push_back(mk(1,0,0,BS,32'h40,0,0, 1,0,32'h40,0,1,1));
    vecs.push_back(mk(1,0,0,BS,32'h40,0,0, 1,0,32'h40,0,1,1));
    vecs.push_back(mk(1,0,0,AC,32'h40,0,0, 1,0,32'h40,0,0,1));
    vecs.push_back(mk(0,0,0,FR,0,0,0, 0,0,0,0,1,1));
    // 2-word dcache fill with icache pending
    vecs.push_back(mk(1,1,0,FR,32'h44,32'h100,0, 0,0,0,0,1,1));
    vecs.push_back(mk(1,1,0,AC,32'h44,32'h100,0, 1,0,32'h100,0,1,0));
    vecs.push_back(mk(1,1,0,AC,32'h44,32'h104,0, 1,0,32'h104,0,1,0));
    vecs.push_back(mk(1,0,0,FR,32'h44,0,0, 0,0,0,0,1,1));
    vecs.push_back(mk(1,0,0,FR,32'h44,0,0, 0,0,0,0,1,1));
    vecs.push_back(mk(1,0,0,AC,32'h44,0,0, 1,0,32'h44,0,0,1));
    // four dcache transactions with iREN held build the streak to 4
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(mk(1,1,0,FR,32'h80,32'h300 + 32'(4*k),0, 0,0,0,0,1,1));
      vecs.push_back(mk(1,1,0,AC,32'h80,32'h300 + 32'(4*k),0, 1,0,32'h300 + 32'(4*k),0,1,0));
      vecs.push_back(mk(1,0,0,FR,32'h80,0,0, 0,0,0,0,1,1));
    end
    // fifth arbitration goes to the icache, then the cleared streak lets the dcache win again
    vecs.push_back(mk(1,1,0,FR,32'h80,32'h310,0, 0,0,0,0,1,1));
    vecs.push_back(mk(1,1,0,AC,32'h80,32'h310,0, 1,0,32'h80,0,0,1));
    vecs.push_back(mk(1,1,0,FR,32'h80,32'h310,0, 0,0,0,0,1,1));
    vecs.push_back(mk(1,1,0,AC,32'h80,32'h310,0, 1,0,32'h310,0,1,0));
    vecs.push_back(mk(0,0,0,FR,0,0,0, 0,0,0,0,1,1));
    // dREN drops before ACCESS; pending iREN granted after the bubble, then iREN drops mid-word
    vecs.push_back(mk(1,1,0,FR,32'h48,32'h180,0, 0,0,0,0,1,1));
    vecs.push_back(mk(1,1,0,BS,32'h48,32'h180,0, 1,0,32'h180,0,1,1));
    vecs.push_back(mk(1,0,0,BS,32'h48,0,0, 0,0,0,0,1,1));
    vecs.push_back(mk(1,0,0,FR,32'h48,0,0, 0,0,0,0,1,1));
    vecs.push_back(mk(1,0,0,BS,32'h48,0,0, 1,0,32'h48,0,1,1));
    vecs.push_back(mk(0,0,0,BS,0,0,0, 0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,FR,0,0,0, 0,0,0,0,1,1));
    // reset state and asynchronous reset in the middle of a dcache grant
    repeat (2) @(negedge CLK);
    RST = 0;
    #1 chk("reset_state", outs(), {4'b0011, 64'h0});
    @(negedge CLK);
    dREN = 1; daddr = 32'h500;
    #1 chk("rst_bubble", outs(), {4'b0011, 64'h0});
    @(negedge CLK);
    #1 chk("rst_dgnt", outs(), {4'b1011, 32'h500, 32'h0});
    #2 RST = 1;
    #1 chk("rst_async", outs(), {4'b0011, 64'h0});
    @(negedge CLK);
    RST = 0;
    #1 chk("rst_idle", outs(), {4'b0011, 64'h0});
    @(negedge CLK);
    #1 chk("rst_regrant", outs(), {4'b1011, 32'h500, 32'h0});
    @(negedge CLK);
    dREN = 0; daddr = 0;
    #1 chk("rst_release", outs(), {4'b0011, 64'h0});
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    // writeback with three ERROR cycles, from a fresh reset so the statistics start at zero
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    apply(mk(0,0,1,FR,0,32'h200,32'hDEADBEEF, 0,0,0,0,1,1), 100);
    for (int k = 0; k < 3; k++)
      apply(mk(0,0,1,ER,0,32'h200,32'hDEADBEEF, 0,1,32'h200,32'hDEADBEEF,1,1), 101 + k);
    apply(mk(0,0,1,AC,0,32'h200,32'hDEADBEEF, 0,1,32'h200,32'hDEADBEEF,1,0), 104);
    apply(mk(0,0,0,FR,0,0,0, 0,0,0,0,1,1), 105);
`ifdef MEMARB_STATS_EN
    #1 chk("stats", {4'b0, dgrants, errcycles}, {4'b0, 32'd1, 32'd3});
    chk("igrants", {36'b0, igrants}, 68'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
